voxel_stream_loader: RTL

//  Parametrised world loader between uart_receiver and l3_cache. Frames the incoming byte

---
 rtl/voxel_stream_loader.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/voxel_stream_loader.sv
// Frames a UART byte stream on a sync marker and writes block types across a
// LENGTH x WIDTH x HEIGHT volume in x-fastest scan order. Optional VOXEL_LOADER_RLE_EN adds run-length expansion.
module voxel_stream_loader #(
    parameter int unsigned LENGTH         = 64,
    parameter int unsigned WIDTH          = 64,
    parameter int unsigned HEIGHT         = 16,
    parameter int unsigned BLOCK_BITS     = 5,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [7:0]                byte_in,
    input  logic                      byte_valid_in,
    input  logic                      start_in,
    input  logic                      wr_ready_in,
    output logic                      wr_en_out,
    output logic [$clog2(LENGTH)-1:0] wr_x_out,
    output logic [$clog2(WIDTH)-1:0]  wr_y_out,
    output logic [$clog2(HEIGHT)-1:0] wr_z_out,
    output logic [BLOCK_BITS-1:0]     wr_data_out,
    output logic                      loaded_out,
    output logic                      busy_out,
    output logic                      error_out
);

    localparam int unsigned X_W = $clog2(LENGTH);
    localparam int unsigned Y_W = $clog2(WIDTH);
    localparam int unsigned Z_W = $clog2(HEIGHT);
    localparam int unsigned T_W = $clog2(TIMEOUT_CYCLES + 1);
`ifdef VOXEL_LOADER_RLE_EN
    localparam int unsigned RUN_W = 8 - BLOCK_BITS;
    localparam int unsigned BUF_W = 8;
`else
    localparam int unsigned BUF_W = BLOCK_BITS;
`endif

    typedef enum logic [1:0] {ST_SYNC, ST_LOAD, ST_DONE, ST_ERROR} state_t;

    state_t           state;
    logic             buf_valid;
    logic [BUF_W-1:0] buf_byte;
    logic [T_W-1:0]   tmo_cnt;
`ifdef VOXEL_LOADER_RLE_EN
    logic [RUN_W-1:0] run_cnt;
`endif

    logic             accept;
    logic             x_last;
    logic             y_last;
    logic             z_last;
    logic             at_last;
    logic [X_W-1:0]   x_nxt;
    logic [Y_W-1:0]   y_nxt;
    logic [Z_W-1:0]   z_nxt;
    logic             load_slot;
    logic             src_valid;
    logic [BUF_W-1:0] src_byte;
    logic             overflow;
    logic             timeout_hit;

    // Handshake, scan-order successor and next-write source selection
    always_comb begin
        accept  = wr_en_out && wr_ready_in;
        x_last  = (wr_x_out == X_W'(LENGTH - 1));
        y_last  = (wr_y_out == Y_W'(WIDTH - 1));
        z_last  = (wr_z_out == Z_W'(HEIGHT - 1));
        at_last = x_last && y_last && z_last;

        x_nxt = x_last ? '0 : wr_x_out + X_W'(1);
        y_nxt = wr_y_out;
        z_nxt = wr_z_out;
        if (x_last) begin
            y_nxt = y_last ? '0 : wr_y_out + Y_W'(1);
            if (y_last) begin
                z_nxt = wr_z_out + Z_W'(1);
            end
        end

`ifdef VOXEL_LOADER_RLE_EN
        load_slot = !wr_en_out || (accept && (run_cnt == '0));
`else
        load_slot = !wr_en_out || accept;
`endif
        // Buffered byte is older than the incoming one, so it goes first
        src_valid   = buf_valid || byte_valid_in;
        src_byte    = buf_valid ? buf_byte : byte_in[BUF_W-1:0];
        overflow    = byte_valid_in && buf_valid && !load_slot;
        timeout_hit = !wr_en_out && !byte_valid_in &&
                      (tmo_cnt == T_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= ST_SYNC;
            wr_en_out   <= 1'b0;
            wr_x_out    <= '0;
            wr_y_out    <= '0;
            wr_z_out    <= '0;
            wr_data_out <= '0;
            loaded_out  <= 1'b0;
            busy_out    <= 1'b1;
            error_out   <= 1'b0;
            buf_valid   <= 1'b0;
            buf_byte    <= '0;
            tmo_cnt     <= '0;
`ifdef VOXEL_LOADER_RLE_EN
            run_cnt     <= '0;
`endif
        end else if (start_in) begin
            state       <= ST_SYNC;
            wr_en_out   <= 1'b0;
            wr_x_out    <= '0;
            wr_y_out    <= '0;
            wr_z_out    <= '0;
            wr_data_out <= '0;
            loaded_out  <= 1'b0;
            busy_out    <= 1'b1;
            error_out   <= 1'b0;
            buf_valid   <= 1'b0;
            buf_byte    <= '0;
            tmo_cnt     <= '0;
`ifdef VOXEL_LOADER_RLE_EN
            run_cnt     <= '0;
`endif
        end else begin
            case (state)
                ST_SYNC: begin
                    if (byte_valid_in && (byte_in == SYNC_BYTE)) begin
                        state   <= ST_LOAD;
                        tmo_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    // Idle timer only runs while nothing is waiting on the cache
                    if (byte_valid_in) begin
                        tmo_cnt <= '0;
                    end else if (!wr_en_out) begin
                        tmo_cnt <= tmo_cnt + T_W'(1);
                    end

                    if (accept && at_last) begin
                        state      <= ST_DONE;
                        wr_en_out  <= 1'b0;
                        loaded_out <= 1'b1;
                        busy_out   <= 1'b0;
                        buf_valid  <= 1'b0;
`ifdef VOXEL_LOADER_RLE_EN
                        run_cnt    <= '0;
`endif
                    end else if (overflow || timeout_hit) begin
                        state     <= ST_ERROR;
                        wr_en_out <= 1'b0;
                        error_out <= 1'b1;
                        busy_out  <= 1'b0;
                        buf_valid <= 1'b0;
                    end else begin
                        if (accept) begin
                            wr_x_out <= x_nxt;
                            wr_y_out <= y_nxt;
                            wr_z_out <= z_nxt;
                        end
                        if (load_slot) begin
                            wr_en_out <= src_valid;
                            if (src_valid) begin
                                wr_data_out <= src_byte[BLOCK_BITS-1:0];
`ifdef VOXEL_LOADER_RLE_EN
                                run_cnt     <= src_byte[7:BLOCK_BITS];
`endif
                            end
                            if (buf_valid) begin
                                buf_valid <= byte_valid_in;
                                buf_byte  <= byte_in[BUF_W-1:0];
                            end
                        end else begin
`ifdef VOXEL_LOADER_RLE_EN
                            if (accept) begin
                                run_cnt <= run_cnt - RUN_W'(1);
                            end
`endif
                            if (byte_valid_in) begin
                                buf_valid <= 1'b1;
                                buf_byte  <= byte_in[BUF_W-1:0];
                            end
                        end
                    end
                end
                ST_DONE: begin
                    wr_en_out <= 1'b0;
                end
                ST_ERROR: begin
                    wr_en_out <= 1'b0;
                end
                default: begin
                    state <= ST_SYNC;
                end
            endcase
        end
    end

endmodule
